// File: rtl/uart_rx_if.sv
// Receive-side UART bundle: serial pin in, byte/strobe outputs toward the command parser.
interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        output rx,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  rx_busy
    );

    modport slave (
        input  rx,
        output rx_data,
        output rx_valid,
        output frame_err,
        output rx_busy
    );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop sync, oversampled bit timing, 3-sample majority vote,
// one-cycle byte-valid and framing-error strobes.
module uart_rx_byte #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input logic    clk,
    input logic    rst,
    uart_rx_if.slave bus
);
    localparam int unsigned DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SW  = $clog2(OVERSAMPLE);

    localparam logic [CW-1:0] CntLast = CW'(DIV - 1);
    localparam logic [SW-1:0] SLast   = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SMidLo  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SMid    = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SMidHi  = SW'(OVERSAMPLE / 2 + 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHi} state_e;

    state_e          state_q, state_d;
    logic [1:0]      sync_q;
    logic            rx_s;
    logic [CW-1:0]   cnt_q;
    logic            tick;
    logic [SW-1:0]   s_q, s_d;
    logic [2:0]      smp_q;
    logic            smp_last;
    logic            vote;
    logic [2:0]      idx_q;
    logic [7:0]      shreg_q;
    logic [7:0]      data_q;
    logic            valid_q;
    logic            ferr_q;
    logic            shift_en;
    logic            accept;
    logic            reject;

    assign rx_s = sync_q[1];
    assign tick = (cnt_q == CntLast);

    // The third stop-bit sample is taken on the very tick the decision is made.
    assign smp_last = (s_q == SMidHi) ? rx_s : smp_q[2];
    assign vote     = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_last) | (smp_q[1] & smp_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], bus.rx};
            cnt_q  <= tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (!rx_s) state_d = StStart;
            StStart:  if (tick && s_q == SLast) state_d = vote ? StIdle : StData;
            StData:   if (tick && s_q == SLast && idx_q == 3'd7) state_d = StStop;
            StStop:   if (tick && s_q == SMidHi) state_d = vote ? StIdle : StWaitHi;
            StWaitHi: if (tick && s_q == SLast && rx_s) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.rx_busy = (state_q != StIdle);
        shift_en    = (state_q == StData) && tick && (s_q == SLast);
        accept      = (state_q == StStop) && tick && (s_q == SMidHi) && vote;
        reject      = (state_q == StStop) && tick && (s_q == SMidHi) && !vote;
    end

    // In WAIT_HI the sample counter doubles as the contiguous-high tick count.
    always_comb begin
        s_d = s_q;
        if (state_d != state_q || state_q == StIdle) begin
            s_d = '0;
        end else if (state_q == StWaitHi && !rx_s) begin
            s_d = '0;
        end else if (tick) begin
            s_d = s_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= '0;
            smp_q   <= 3'b111;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            s_q <= s_d;
            if (tick && state_q != StIdle) begin
                if (s_q == SMidLo) smp_q[0] <= rx_s;
                if (s_q == SMid)   smp_q[1] <= rx_s;
                if (s_q == SMidHi) smp_q[2] <= rx_s;
            end
            if (state_q != StData) begin
                idx_q <= '0;
            end else if (shift_en) begin
                idx_q <= idx_q + 1'b1;
            end
            if (shift_en) shreg_q <= {vote, shreg_q[7:1]};
            if (accept)   data_q  <= shreg_q;
            valid_q <= accept;
            ferr_q  <= reject;
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at a reduced clock (4 clks per tick, 64 clks per bit).
`timescale 1ns/1ps
module tb_uart_rx_byte;
    localparam realtime BitNs = 640.0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_rx_if bus ();

    uart_rx_byte #(
        .CLK_FREQ  (614_400),
        .BAUD      (9600),
        .OVERSAMPLE(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int         n_valid = 0;
    int         n_ferr  = 0;
    int         n_both  = 0;
    int         n_long  = 0;
    logic       prev_v  = 1'b0;
    logic       prev_f  = 1'b0;
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            n_valid++;
            got_q.push_back(bus.rx_data);
        end
        if (bus.frame_err === 1'b1) n_ferr++;
        if (bus.rx_valid === 1'b1 && bus.frame_err === 1'b1) n_both++;
        if ((bus.rx_valid === 1'b1 && prev_v) || (bus.frame_err === 1'b1 && prev_f)) n_long++;
        prev_v = (bus.rx_valid === 1'b1);
        prev_f = (bus.frame_err === 1'b1);
    end

    // spike >= 0 puts a 40 ns low pulse near the receiver's mid-bit samples of that bit.
    task automatic send_byte(input logic [7:0] b, input realtime bt, input logic stop,
                             input int spike);
        bus.rx = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            if (i == spike) begin
                #(bt / 2 + 70.0);
                bus.rx = 1'b0;
                #(40.0);
                bus.rx = b[i];
                #(bt / 2 - 110.0);
            end else begin
                #(bt);
            end
        end
        bus.rx = stop;
        #(bt);
    endtask

    initial begin
        int         v0, f0, base, k;
        logic [7:0] burst [7];
        logic [7:0] got;
        burst = '{8'h52, 8'h45, 8'h53, 8'h45, 8'h54, 8'h0D, 8'h0A};

        bus.rx = 1'b1;
        rst    = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset_data", 32'(bus.rx_data), 32'h00);
        check_eq("reset_valid", 32'(bus.rx_valid), 0);
        check_eq("reset_ferr", 32'(bus.frame_err), 0);
        check_eq("reset_busy", 32'(bus.rx_busy), 0);
        #(BitNs);

        // Single byte 'L'
        v0 = n_valid; f0 = n_ferr;
        send_byte(8'h4C, BitNs, 1'b1, -1);
        #(BitNs);
        check_eq("l_valid_cnt", 32'(n_valid - v0), 1);
        check_eq("l_data", 32'(bus.rx_data), 32'h4C);
        check_eq("l_ferr_cnt", 32'(n_ferr - f0), 0);

        // Start-bit glitch of 3 ticks
        v0 = n_valid; f0 = n_ferr;
        bus.rx = 1'b0;
        #(40.0);
        check_eq("glitch_busy_hi", 32'(bus.rx_busy), 1);
        #(80.0);
        bus.rx = 1'b1;
        #(600.0);
        check_eq("glitch_busy_lo", 32'(bus.rx_busy), 0);
        check_eq("glitch_valid_cnt", 32'(n_valid - v0), 0);
        check_eq("glitch_ferr_cnt", 32'(n_ferr - f0), 0);

        // Framing error, then wait for a full bit period of idle before next byte
        v0 = n_valid; f0 = n_ferr;
        send_byte(8'h55, BitNs, 1'b0, -1);
        bus.rx = 1'b1;
        check_eq("ferr_cnt", 32'(n_ferr - f0), 1);
        check_eq("ferr_valid_cnt", 32'(n_valid - v0), 0);
        check_eq("ferr_data_kept", 32'(bus.rx_data), 32'h4C);
        #(480.0);
        check_eq("waithi_busy", 32'(bus.rx_busy), 1);
        #(240.0);
        check_eq("waithi_done", 32'(bus.rx_busy), 0);
        v0 = n_valid;
        send_byte(8'h0A, BitNs, 1'b1, -1);
        #(BitNs);
        check_eq("after_ferr_cnt", 32'(n_valid - v0), 1);
        check_eq("after_ferr_data", 32'(bus.rx_data), 32'h0A);

        // Back-to-back "RESET\r\n" with no idle gap
        base = got_q.size(); v0 = n_valid; f0 = n_ferr;
        for (int i = 0; i < 7; i++) begin
            fork
                send_byte(burst[i], BitNs, 1'b1, -1);
                begin
                    #(5 * BitNs);
                    check_eq($sformatf("burst_busy_%0d", i), 32'(bus.rx_busy), 1);
                end
            join
        end
        #(BitNs);
        check_eq("burst_cnt", 32'(n_valid - v0), 7);
        check_eq("burst_ferr", 32'(n_ferr - f0), 0);
        check_eq("burst_idle", 32'(bus.rx_busy), 0);
        for (int i = 0; i < 7; i++) begin
            got = (base + i < got_q.size()) ? got_q[base + i] : 8'hxx;
            check_eq($sformatf("burst_byte_%0d", i), 32'(got), 32'(burst[i]));
        end

        // Reset pulse during data bit 4 of 0x44
        fork
            send_byte(8'h44, BitNs, 1'b1, -1);
            begin
                #(5 * BitNs + BitNs / 2);
                @(negedge clk);
                v0 = n_valid; f0 = n_ferr;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_eq("rst_data", 32'(bus.rx_data), 32'h00);
                check_eq("rst_valid", 32'(bus.rx_valid), 0);
                check_eq("rst_ferr", 32'(bus.frame_err), 0);
                check_eq("rst_busy", 32'(bus.rx_busy), 0);
            end
        join
        check_eq("rst_no_valid", 32'(n_valid - v0), 0);
        check_eq("rst_no_ferr", 32'(n_ferr - f0), 0);
        #(10 * BitNs);
        k = 0;
        while (bus.rx_busy === 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check_eq("rst_settle_idle", 32'(bus.rx_busy), 0);
        v0 = n_valid;
        send_byte(8'h44, BitNs, 1'b1, -1);
        #(BitNs);
        check_eq("post_rst_cnt", 32'(n_valid - v0), 1);
        check_eq("post_rst_data", 32'(bus.rx_data), 32'h44);

        // 2% fast line with a one-tick spike in bit 2
        v0 = n_valid; f0 = n_ferr;
        send_byte(8'h4F, 627.0, 1'b1, 2);
        #(BitNs);
        check_eq("spike_cnt", 32'(n_valid - v0), 1);
        check_eq("spike_data", 32'(bus.rx_data), 32'h4F);
        check_eq("spike_ferr", 32'(n_ferr - f0), 0);

        check_eq("strobe_overlap", 32'(n_both), 0);
        check_eq("strobe_width", 32'(n_long), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
